// File: rtl/shift_pkg.sv
// Shared definitions for shift_seq_ctrl: shift register command encoding
// and the sequencer FSM state type.
package shift_pkg;

    localparam logic [1:0] SR_HOLD = 2'd0;
    localparam logic [1:0] SR_SHL  = 2'd1;
    localparam logic [1:0] SR_SHR  = 2'd2;
    localparam logic [1:0] SR_LOAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the requester after the
// last accepted one; the pointer only moves on an accept strobe.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_id
);

    logic [IW-1:0] last_q;
    logic          found;
    int unsigned   idx;

    // Pick the first valid requester starting at last_q+1, wrapping around.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last_q) + i) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Remember the most recent winner; reset value makes requester 0 win first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= IW'(NREQ - 1);
        end else if (accept) begin
            last_q <= grant_id;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: arbitrates requesters, loads an external shift register,
// steps it amt_eff times and returns the result with the owner's id.
// Optional per-requester grant counters: define SHIFT_SEQ_STATS_EN.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter  int N    = 16,
    parameter  int NREQ = 2,
    localparam int CW   = $clog2(N) + 1,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*N-1:0]  req_data,
    input  logic [NREQ-1:0]    req_dir,
    input  logic [NREQ*CW-1:0] req_amt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [N-1:0]       rsp_data,
    output logic [IW-1:0]      rsp_id,
    output logic [1:0]         sr_control,
    output logic [N-1:0]       sr_data_in,
    input  logic [N-1:0]       sr_data_out,
`ifdef SHIFT_SEQ_STATS_EN
    output logic               busy,
    output logic [NREQ*16-1:0] stat_grants
`else
    output logic               busy
`endif
);

    localparam logic [CW-1:0] N_AMT = CW'(N);

    state_t          state_q, state_d;
    logic [N-1:0]    data_q;
    logic            dir_q;
    logic [IW-1:0]   id_q;
    logic [CW-1:0]   cnt_q;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_id;
    logic            accept;
    logic [CW-1:0]   amt_sel;
    logic [CW-1:0]   amt_eff;

    // Accept only in IDLE and never while reset is held (outputs must stay 0).
    assign accept  = reset && (state_q == ST_IDLE) && (|req_valid);
    assign amt_sel = req_amt[grant_id*CW +: CW];
    assign amt_eff = (amt_sel > N_AMT) ? N_AMT : amt_sel;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req_valid),
        .accept   (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the granted operand on accept; count down remaining shift steps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            dir_q  <= 1'b0;
            id_q   <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            data_q <= req_data[grant_id*N +: N];
            dir_q  <= req_dir[grant_id];
            id_q   <= grant_id;
            cnt_q  <= amt_eff;
        end else if (state_q == ST_SHIFT) begin
            cnt_q  <= cnt_q - CW'(1);
        end
    end

    // Next-state decode and all command/response outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        rsp_id     = '0;
        sr_control = SR_HOLD;
        sr_data_in = '0;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    req_ready = grant;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sr_control = SR_LOAD;
                sr_data_in = data_q;
                state_d    = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                sr_control = dir_q ? SR_SHR : SR_SHL;
                sr_data_in = sr_data_out;
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                rsp_data  = sr_data_out;
                rsp_id    = id_q;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef SHIFT_SEQ_STATS_EN
    // Per-requester saturating grant counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_grants <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (grant[i] && (stat_grants[i*16 +: 16] != 16'hFFFF)) begin
                    stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl with a behavioural shift register and
// a round-robin / shift-result reference model.
module tb_shift_seq_ctrl;

    localparam int N    = 16;
    localparam int NREQ = 2;
    localparam int CW   = $clog2(N) + 1;
    localparam int IW   = $clog2(NREQ);

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*N-1:0]  req_data;
    logic [NREQ-1:0]    req_dir;
    logic [NREQ*CW-1:0] req_amt;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [N-1:0]       rsp_data;
    logic [IW-1:0]      rsp_id;
    logic [1:0]         sr_control;
    logic [N-1:0]       sr_data_in;
    logic [N-1:0]       sr_data_out;
    logic               busy;
`ifdef SHIFT_SEQ_STATS_EN
    logic [NREQ*16-1:0] stat_grants;
`endif

    shift_seq_ctrl #(.N(N), .NREQ(NREQ)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_dir     (req_dir),
        .req_amt     (req_amt),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .sr_control  (sr_control),
        .sr_data_in  (sr_data_in),
        .sr_data_out (sr_data_out),
`ifdef SHIFT_SEQ_STATS_EN
        .busy        (busy),
        .stat_grants (stat_grants)
`else
        .busy        (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [N-1:0] data;
        int           cycle;
        int           amt;
        int           shift_base;
        int           stall;
    } exp_t;

    exp_t q[$];
    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int shift_cnt  = 0;
    int model_last = NREQ - 1;
    int model_free = 0;
    logic [N-1:0] sr_q = '0;

    assign sr_data_out = sr_q;

    // External shift register, cycle counter and shift-cycle counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sr_control inside {2'd1, 2'd2}) shift_cnt <= shift_cnt + 1;
        case (sr_control)
            2'd1:    sr_q <= sr_data_in << 1;
            2'd2:    sr_q <= sr_data_in >> 1;
            2'd3:    sr_q <= sr_data_in;
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] mask);
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx = (last + i) % NREQ;
            if (mask[idx]) return idx;
        end
        return 0;
    endfunction

    // While the model says the block is busy, no grant may appear.
    task automatic wait_free();
        while (cyc < model_free) begin
            @(negedge clk);
            chk("no_grant_busy", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_txn(input logic [NREQ-1:0] mask,
                          input logic [N-1:0] d0, input logic [N-1:0] d1,
                          input logic dr0, input logic dr1,
                          input logic [CW-1:0] a0, input logic [CW-1:0] a1,
                          input int stall, input bit hold, input bit abort);
        int g, amt, acc;
        logic [N-1:0] src;
        logic dsel;
        logic [CW-1:0] asel;
        logic [31:0] wide;
        exp_t e;
        wait_free();
        req_valid = mask;
        req_data  = {d1, d0};
        req_dir   = {dr1, dr0};
        req_amt   = {a1, a0};
        g    = rr_pick(model_last, mask);
        src  = (g == 0) ? d0 : d1;
        dsel = (g == 0) ? dr0 : dr1;
        asel = (g == 0) ? a0 : a1;
        amt  = (int'(asel) > N) ? N : int'(asel);
        wide = {16'h0, src};
        wide = dsel ? (wide >> amt) : (wide << amt);
        @(negedge clk);
        chk("grant", 32'(req_ready), 32'd1 << g);
        acc = cyc;
        if (!abort) begin
            e.id = g;
            e.data = wide[N-1:0];
            e.cycle = acc + 2 + amt;
            e.amt = amt;
            e.shift_base = shift_cnt;
            e.stall = stall;
            q.push_back(e);
            model_free = acc + 3 + amt + stall;
        end
        model_last = g;
        @(posedge clk);
        #1;
        if (!hold) req_valid = '0;
    endtask

    // Monitor: pops the scoreboard on each response and applies the stall.
    initial begin
        exp_t e;
        logic [N-1:0] d0;
        logic [IW-1:0] i0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_cycle", 32'(cyc), 32'(e.cycle));
                    chk("shift_cycles", 32'(shift_cnt - e.shift_base), 32'(e.amt));
                    chk("busy_done", 32'(busy), 32'd1);
                    d0 = rsp_data;
                    i0 = rsp_id;
                    for (int s = 0; s < e.stall; s++) begin
                        @(negedge clk);
                        chk("stall_valid", 32'(rsp_valid), 32'd1);
                        chk("stall_data", 32'(rsp_data), 32'(d0));
                        chk("stall_id", 32'(rsp_id), 32'(i0));
                        chk("stall_hold", 32'(sr_control), 32'd0);
                        chk("stall_ready", 32'(req_ready), 32'd0);
                    end
                end
                rsp_ready = 1'b1;
                @(posedge clk);
                #1;
                rsp_ready = 1'b0;
            end
        end
    end

    // Grant exclusivity at every cycle.
    always @(negedge clk) begin
        if ($countones(req_ready) > 1) chk("ready_onehot", 32'(req_ready), 32'd0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        logic [NREQ-1:0] m;
        reset     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        req_dir   = '0;
        req_amt   = '0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_sr_control", 32'(sr_control), 32'd0);
        chk("rst_sr_data_in", 32'(sr_data_in), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_free = cyc;

        // Left by 4, amount 0, clamped right shift, stall with other requester waiting.
        do_txn(2'b01, 16'h00F0, 16'h0000, 1'b0, 1'b0, 5'd4, 5'd0, 0, 1'b0, 1'b0);
        do_txn(2'b10, 16'h0000, 16'hA5A5, 1'b0, 1'b0, 5'd0, 5'd0, 0, 1'b0, 1'b0);
        do_txn(2'b01, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 5'd20, 5'd0, 0, 1'b0, 1'b0);
        do_txn(2'b10, 16'h0000, 16'h1234, 1'b0, 1'b1, 5'd0, 5'd3, 5, 1'b1, 1'b0);

        // Both requesters held valid: grants must alternate.
        for (int k = 0; k < 4; k++) begin
            do_txn(2'b11, 16'h0003, 16'h8000, 1'b0, 1'b1, 5'd2, 5'd15, 0, 1'b1, 1'b0);
        end
        req_valid = '0;

        // Abort mid-SHIFT by reset; requester 0 must win afterwards.
        do_txn(2'b10, 16'h0000, 16'h0F0F, 1'b0, 1'b0, 5'd0, 5'd2, 0, 1'b0, 1'b0);
        do_txn(2'b01, 16'h0101, 16'h0000, 1'b0, 1'b0, 5'd10, 5'd0, 0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_sr_control", 32'(sr_control), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_last = NREQ - 1;
        @(posedge clk);
        #1;
        model_free = cyc;
        do_txn(2'b11, 16'h0011, 16'h0022, 1'b0, 1'b0, 5'd1, 5'd1, 0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 24; k++) begin
            m = NREQ'($urandom_range(1, 3));
            do_txn(m, N'($urandom), N'($urandom), 1'($urandom), 1'($urandom),
                   CW'($urandom_range(0, 31)), CW'($urandom_range(0, 31)),
                   int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end
        req_valid = '0;

        for (int k = 0; k < 200 && (q.size() != 0 || cyc < model_free); k++) begin
            @(posedge clk);
        end
        #1;
        chk("drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter N, default 16: width of the shared shift register.
REQ-002 Parameter NREQ, default 2: number of requesters, range 2..8.
REQ-003 Localparam CW = $clog2(N)+1: shift-amount width.
REQ-004 Localparam IW = $clog2(NREQ): requester-id width.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  NREQ  per-requester request valid.
REQ-008 req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
REQ-009 req_data  in  NREQ*N  per-requester operand; slice i belongs to requester i.
REQ-010 req_dir  in  NREQ  per-requester direction; 0 = left, 1 = right.
REQ-011 req_amt  in  NREQ*CW  per-requester shift amount.
REQ-012 rsp_valid  out  1  result valid.
REQ-013 rsp_ready  in  1  result consumer ready.
REQ-014 rsp_data  out  N  result value.
REQ-015 rsp_id  out  IW  index of the requester that owns the result.
REQ-016 sr_control  out  2  shift register command.
REQ-017 sr_data_in  out  N  shift register operand.
REQ-018 sr_data_out  in  N  shift register current value.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 The shift register command encoding SHALL be: HOLD = 0, SHL = 1 (q <= d<<1), SHR = 2 (q <= d>>1), LOAD = 3 (q <= d).
REQ-021 The FSM SHALL have four states: IDLE, LOAD, SHIFT, DONE.
REQ-022 IDLE: if any req_valid is high, grant one requester round-robin, assert its req_ready for that cycle only, latch data/dir/id and amt_eff = min(req_amt, N), then go to LOAD.
REQ-023 Round-robin: search starts at (last_grant+1) mod NREQ; last_grant is updated on each accept.
REQ-024 LOAD: sr_control = LOAD and sr_data_in = latched operand; next state is SHIFT if amt_eff > 0, else DONE.
REQ-025 SHIFT: sr_control = SHL or SHR according to the latched direction, and sr_data_in = sr_data_out (loopback).
REQ-026 SHIFT: the step counter decrements once per cycle; leave for DONE after exactly amt_eff SHIFT cycles.
REQ-027 DONE: rsp_valid = 1, rsp_data = sr_data_out, rsp_id = latched id, sr_control = HOLD.
REQ-028 DONE: go to IDLE on the cycle rsp_valid && rsp_ready; rsp_data and rsp_id stay stable while stalled.
REQ-029 In IDLE and DONE, sr_control SHALL be HOLD; sr_data_in SHALL be 0 in IDLE.
REQ-030 Latency: accept at cycle 0, rsp_valid first high at cycle 2 + amt_eff.
REQ-031 No request SHALL be accepted outside IDLE; the earliest re-accept is the cycle after the response handshake.
REQ-032 amt >= N SHALL produce all-zero data after N shifts (clamped, not wrapped).
REQ-033 req_valid deasserting before grant SHALL NOT be an error; a requester that is not valid in IDLE is skipped.

Reset
REQ-034 While reset is low: state = IDLE, last_grant = NREQ-1 (requester 0 wins first), counter = 0.
REQ-035 While reset is low, all outputs SHALL be 0, which drives sr_control = HOLD.
REQ-036 Reset asserted mid-operation SHALL abort the operation without producing a response; the shift register content is not cleared by this block.

Configuration
REQ-037 Macro SHIFT_SEQ_STATS_EN.
REQ-038 With SHIFT_SEQ_STATS_EN defined, output stat_grants (NREQ*16) SHALL hold per-requester grant counters: 16-bit, saturating at 0xFFFF, incremented on accept, cleared by reset.
REQ-039 Without SHIFT_SEQ_STATS_EN, the stat_grants port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-040 Package shift_pkg SHALL hold the sr_control encoding constants and the FSM state typedef.
REQ-041 Sub-module rr_arbiter (NREQ, one-hot grant, pointer update on an accept strobe) SHALL be instantiated once.

Verification
REQ-042 Bench SHALL cover: req0 data 0x00F0, left, amt 4 -> rsp_data 0x0F00, rsp_id 0, rsp_valid at cycle 6.
REQ-043 Bench SHALL cover: req1 data 0xA5A5, amt 0 -> rsp_data 0xA5A5, rsp_id 1, rsp_valid at cycle 2, no SHIFT cycles.
REQ-044 Bench SHALL cover: data 0xFFFF, right, amt 20 -> 16 SHR cycles, rsp_data 0x0000 at cycle 18.
REQ-045 Bench SHALL cover: both req_valid held high, rsp_ready = 1 -> grants alternate 0,1,0,1; req_ready never has two bits set.
REQ-046 Bench SHALL cover: rsp_ready low for 5 cycles in DONE -> rsp_data stable, sr_control = HOLD, no req_ready.
REQ-047 Bench SHALL cover: reset low during SHIFT -> next cycle busy = 0, rsp_valid = 0; the first request after release goes to requester 0.
